reg_pipe: RTL and testbench
===========================

// Module: reg_pipe
// PURPOSE
//   Parametrised multi-stage register pipeline with valid/ready flow control, stall and flush.
//   Generalises the single D flop to WIDTH bits x DEPTH stages with backpressure and bubble collapsing.
//   Each data stage is selectable as async-reset or non-reset.
//   Used to retime wide datapaths between blocks without breaking the valid/ready handshake.
// PARAMETERS
//   WIDTH     8    data width in bits (>=1)
//   DEPTH     3    number of register stages (>=1); latency in cycles when not stalled
//   RST_DATA  1    1: data regs async-reset to RST_VAL; 0: data regs have no reset (valids always reset)
//   RST_VAL   '0   reset value of data regs when RST_DATA=1 (WIDTH bits)
// PORTS
//   clk          in   1                   clock, rising edge
//   rst          in   1                   reset, asynchronous, active-high
//   flush_i      in   1                   synchronous clear of all stage valids
//   in_valid_i   in   1                   upstream data valid
//   in_ready_o   out  1                   pipe can accept in_data_i this cycle
//   in_data_i    in   WIDTH               upstream data
//   out_valid_o  out  1                   last stage holds valid data
//   out_ready_i  in   1                   downstream accepts out_data_o this cycle
//   out_data_o   out  WIDTH               last-stage data
//   occupancy_o  out  $clog2(DEPTH+1)     number of stages holding valid data (0..DEPTH)
// BEHAVIOUR
//   - Stage k (0..DEPTH-1) holds v[k] and d[k]; stage 0 fed from input, stage DEPTH-1 drives output.
//   - rdy[DEPTH] = out_ready_i; rdy[k] = !v[k] | rdy[k+1] (bubble collapsing, combinational chain).
//   - Stage k loads when rdy[k]: v[k] <= v[k-1] (v[-1] = in_valid_i), d[k] <= d[k-1] (d[-1] = in_data_i).
//   - d[k] loads only when rdy[k] & upstream valid; otherwise it holds (no toggling on bubbles).
//   - in_ready_o = rdy[0] & !flush_i & !rst; transfer in when in_valid_i & in_ready_o.
//   - out_valid_o = v[DEPTH-1]; out_data_o = d[DEPTH-1]; transfer out when out_valid_o & out_ready_i.
//   - While out_valid_o & !out_ready_i: out_valid_o and out_data_o held stable.
//   - Latency: item accepted at edge N appears on out_valid_o after edge N+DEPTH-1 (DEPTH cycles) if no stall.
//   - Throughput: 1 item/cycle with out_ready_i held high; no bubbles inserted by the pipe.
//   - Capacity: exactly DEPTH items; when all v=1 and out_ready_i=0, in_ready_o=0.
//   - Full pipe + out_ready_i=1: simultaneous in/out transfer; occupancy stays DEPTH.
//   - occupancy_o = popcount(v), combinational from the valid registers.
//   - Ordering: strictly FIFO; no drop or duplicate except on flush.
//   - flush_i: at next edge all v <= 0; input presented during the flush cycle is dropped.
//   - flush_i has priority over every load and is independent of out_ready_i.
//   - rst asserted: all v = 0 immediately; out_valid_o = 0, occupancy_o = 0, in_ready_o = 0.
//   - Data on rst: RST_DATA=1 -> all d = RST_VAL; RST_DATA=0 -> d unchanged/unknown.
//   - After rst deasserts: in_ready_o = 1 (pipe empty).
//   - rst mid-stream: all in-flight items discarded; no partial output after release.
//   - out_data_o is don't-care while out_valid_o=0.
// TESTING
//   1 Stream (WIDTH=8, DEPTH=3): push 11,22,33 back-to-back, out_ready=1 -> out 11,22,33 on 3 consecutive cycles starting 3 cycles after first accept.
//   2 Backpressure: out_ready=0, offer 4 items -> 3 accepted, in_ready=0, occupancy=3, out_data=first item held; out_ready=1 -> remaining 3 items delivered in order, 4th item accepted.
//   3 Bubble collapse: push A, gap 2 cycles, push B with out_ready=0 -> occupancy=2; out_ready=1 -> A then B on consecutive cycles.
//   4 Flush: full pipe, flush_i=1 with in_valid_i=1 -> next cycle occupancy=0, out_valid=0, flushed input never appears.
//   5 Async reset mid-stream: assert rst between edges with occupancy=2 -> out_valid=0 and occupancy=0 before next edge; after release in_ready=1.
//   6 RST_DATA=1, RST_VAL=8'hA5 -> out_data_o=A5 during reset; RST_DATA=0 -> checker ignores data while out_valid=0.

Source files
------------

// File: rtl/reg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : reg_pipe
// Purpose  : WIDTH x DEPTH register pipeline with valid/ready flow control,
//            bubble collapsing, synchronous flush and optional data reset.
// Revision : 1.0 - initial release
// ============================================================================
module reg_pipe #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 3,
  parameter bit               RST_DATA = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_vin;
  logic [WIDTH-1:0] w_din  [DEPTH];
  logic [DEPTH-1:0] w_load;
  logic [OCC_W-1:0] w_occ;
  logic             w_chain;

  // Ready ripples from the output back; an empty stage absorbs a stall below it.
  always_comb begin
    w_chain = out_ready_i;
    w_rdy   = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      w_chain  = !r_valid[k] | w_chain;
      w_rdy[k] = w_chain;
    end
  end

  always_comb begin
    w_vin[0] = in_valid_i;
    w_din[0] = in_data_i;
    for (int k = 1; k < DEPTH; k++) begin
      w_vin[k] = r_valid[k-1];
      w_din[k] = r_data[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_load[k] = w_rdy[k] & w_vin[k] & !flush_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_rdy[k]) begin
          r_valid[k] <= w_vin[k];
        end
      end
    end
  end

  // Data registers only move on a real transfer so bubbles do not toggle them.
  if (RST_DATA) begin : g_data_rst
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) begin
          r_data[k] <= RST_VAL;
        end
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (w_load[k]) begin
            r_data[k] <= w_din[k];
          end
        end
      end
    end
  end else begin : g_data_nrst
    always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_load[k]) begin
          r_data[k] <= w_din[k];
        end
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + OCC_W'(r_valid[k]);
    end
  end

  assign in_ready_o  = w_rdy[0] & !flush_i & !rst;
  assign out_valid_o = r_valid[DEPTH-1];
  assign out_data_o  = r_data[DEPTH-1];
  assign occupancy_o = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_reg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_pipe
// Purpose  : Scoreboard bench for reg_pipe (WIDTH=8, DEPTH=3), with a second
//            no-data-reset instance cross-checked against the first.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_pipe;

  localparam int W = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occ;
  logic         nr_in_ready, nr_out_valid;
  logic [W-1:0] nr_out_data;
  logic [1:0]   nr_occ;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] exp_d;

  always #5 clk = ~clk;

  reg_pipe #(.WIDTH(W), .DEPTH(D), .RST_DATA(1'b1), .RST_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .in_data_i(in_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .occupancy_o(occ));

  reg_pipe #(.WIDTH(W), .DEPTH(D), .RST_DATA(1'b0), .RST_VAL(8'h00)) dut_nr (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(nr_in_ready), .in_data_i(in_data), .out_valid_o(nr_out_valid),
    .out_ready_i(out_ready), .out_data_o(nr_out_data), .occupancy_o(nr_occ));

  always @(posedge rst) q.delete();

  // Scoreboard: transfers are decided by the values stable at mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (nr_out_valid !== out_valid || nr_occ !== occ || nr_in_ready !== in_ready)
        $display("FAIL nr_match: nr v/occ/rdy=%b/%0d/%b required %b/%0d/%b",
                 nr_out_valid, nr_occ, nr_in_ready, out_valid, occ, in_ready);
      else n_pass++;
      if (out_valid === 1'b1) begin
        n_checks++;
        if (nr_out_data !== out_data)
          $display("FAIL nr_data: got %h required %h", nr_out_data, out_data);
        else n_pass++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid === 1'b1 && out_ready) begin
          n_checks++;
          if (q.size() == 0) begin
            $display("FAIL sb_unexpected: got %h required no output", out_data);
          end else begin
            exp_d = q.pop_front();
            if (out_data !== exp_d)
              $display("FAIL sb_data: got %h required %h", out_data, exp_d);
            else n_pass++;
          end
        end
        if (in_valid && in_ready === 1'b1) q.push_back(in_data);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int budget;
    budget = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (occ !== 2'd0 && budget < 20) begin
      tick();
      budget++;
    end
    n_checks++;
    if (occ !== 2'd0 || q.size() != 0)
      $display("FAIL drain: occ=%0d queue=%0d required 0/0", occ, q.size());
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || occ !== 2'd0 || out_data !== 8'hA5)
      $display("FAIL reset_state: rdy/v/occ/data=%b/%b/%0d/%h required 0/0/0/a5",
               in_ready, out_valid, occ, out_data);
    else n_pass++;
    @(posedge clk); #2;
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: rdy/v=%b/%b required 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_stream;
    logic [W-1:0] sv [3];
    sv[0] = 8'h11; sv[1] = 8'h22; sv[2] = 8'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = sv[i];
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== sv[i])
        $display("FAIL stream_out%0d: v/data=%b/%h required 1/%h", i, out_valid, out_data, sv[i]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0)
      $display("FAIL stream_end: v/occ=%b/%0d required 0/0", out_valid, occ);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [W-1:0] it [4];
    int idx;
    logic acc;
    it[0] = 8'h41; it[1] = 8'h42; it[2] = 8'h43; it[3] = 8'h44;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = it[idx];
      acc = in_ready;
      tick();
      if (acc && idx < 3) idx++;
    end
    n_checks++;
    if (idx != 3 || in_ready !== 1'b0 || occ !== 2'd3 || out_valid !== 1'b1 || out_data !== 8'h41)
      $display("FAIL bp_full: acc/rdy/occ/v/data=%0d/%b/%0d/%b/%h required 3/0/3/1/41",
               idx, in_ready, occ, out_valid, out_data);
    else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1)
      $display("FAIL bp_full_ready: rdy=%b required 1", in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (occ !== 2'd3 || out_data !== 8'h42)
      $display("FAIL bp_passthru: occ/data=%0d/%h required 3/42", occ, out_data);
    else n_pass++;
    drain();
  endtask

  task automatic test_bubble;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 8'hBB; tick();
    in_valid = 1'b0; tick();
    n_checks++;
    if (occ !== 2'd2 || out_data !== 8'hAA)
      $display("FAIL bubble_occ: occ/data=%0d/%h required 2/aa", occ, out_data);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hBB)
      $display("FAIL bubble_next: v/data=%b/%h required 1/bb", out_valid, out_data);
    else n_pass++;
    drain();
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h60 + 8'(i); tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    #1;
    n_checks++;
    if (in_ready !== 1'b0)
      $display("FAIL flush_ready: rdy=%b required 0", in_ready);
    else n_pass++;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (occ !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL flush_clear: occ/v=%0d/%b required 0/0", occ, out_valid);
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0)
        $display("FAIL flush_ghost: v=%b data=%h required v=0", out_valid, out_data);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h51; tick();
    in_data = 8'h52; tick();
    in_valid = 1'b0;
    n_checks++;
    if (occ !== 2'd2)
      $display("FAIL areset_pre: occ=%0d required 2", occ);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b0 || out_data !== 8'hA5 || nr_out_valid !== 1'b0)
      $display("FAIL areset_now: v/occ/rdy/data/nrv=%b/%0d/%b/%h/%b required 0/0/0/a5/0",
               out_valid, occ, in_ready, out_data, nr_out_valid);
    else n_pass++;
    #1 rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL areset_release: rdy/v=%b/%b required 1/0", in_ready, out_valid);
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0)
        $display("FAIL areset_ghost: v=%b required 0", out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (in_ready !== ((occ < 2'd3) || out_ready))
        $display("FAIL rand_ready: rdy=%b occ=%0d ordy=%b", in_ready, occ, out_ready);
      else n_pass++;
      tick();
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
